uart_frame_serializer: RTL



---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_parity_gen.sv | 10 +
 rtl/uart_frame_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, transmit state encoding and frame length helper
package uart_pkg;
    localparam int PARITY_NONE = 0, PARITY_EVEN = 1, PARITY_ODD = 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    function automatic int frame_len(int data_bits, int parity_mode, int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction
endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: combinational parity bit for a word; 0 when parity is disabled
module uart_parity_gen import uart_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int MODE  = PARITY_EVEN
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);
    assign parity = (MODE == PARITY_NONE) ? 1'b0 : (MODE == PARITY_ODD) ? ~^data : ^data;
endmodule

// File: rtl/uart_frame_serializer.sv
// uart_frame_serializer: UART transmit framer with a one-word holding buffer, one bit per baud_tick
module uart_frame_serializer import uart_pkg::*; #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx_line,
    output logic                 busy,
    output logic                 frame_done
);
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_frame_serializer: illegal parameter combination");
        end
    endgenerate

    tx_state_t            state, state_nx;
    logic [DATA_BITS-1:0] shift, shift_nx, hold_data;
    logic [3:0]           cnt, cnt_nx;
    logic                 par, par_nx, hold_par, hold_full, tx_nx, done_nx, load;

    uart_parity_gen #(.WIDTH(DATA_BITS), .MODE(PARITY_MODE)) u_parity (
        .data   (hold_data),
        .parity (hold_par)
    );

    assign data_ready = !hold_full;
    assign busy       = (state != IDLE) || hold_full;

    // tx_nx is the level of the bit period that starts at this tick edge
    always_comb begin
        state_nx = state;
        shift_nx = shift;
        par_nx   = par;
        cnt_nx   = cnt;
        tx_nx    = tx_line;
        done_nx  = 1'b0;
        load     = 1'b0;
        if (baud_tick) begin
            case (state)
                IDLE:   load = hold_full;
                START: begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    tx_nx    = shift[0];
                end
                DATA: begin
                    shift_nx = shift >> 1;
                    cnt_nx   = cnt + 4'd1;
                    if (cnt == 4'(DATA_BITS - 1)) begin
                        state_nx = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        cnt_nx   = '0;
                        tx_nx    = (PARITY_MODE != PARITY_NONE) ? par : 1'b1;
                    end else begin
                        tx_nx = shift[1];
                    end
                end
                PARITY: begin
                    state_nx = STOP;
                    cnt_nx   = '0;
                    tx_nx    = 1'b1;
                end
                STOP: begin
                    cnt_nx = cnt + 4'd1;
                    tx_nx  = 1'b1;
                    if (cnt == 4'(STOP_BITS - 1)) begin
                        done_nx  = 1'b1;
                        load     = hold_full;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (load) begin
            state_nx = START;
            shift_nx = hold_data;
            par_nx   = hold_par;
            cnt_nx   = '0;
            tx_nx    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            par        <= 1'b0;
            cnt        <= '0;
            tx_line    <= 1'b1;
            frame_done <= 1'b0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
        end else begin
            state      <= state_nx;
            shift      <= shift_nx;
            par        <= par_nx;
            cnt        <= cnt_nx;
            tx_line    <= tx_nx;
            frame_done <= done_nx;
            if (load)
                hold_full <= 1'b0;
            else if (data_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= data_in;
            end
        end
    end
endmodule
